// File: rtl/dm_sba_regs_pkg.sv
// Shared types for the debug-module system bus access register block:
// sbcs layout, DMI register addresses and DMI operation encoding.
package dm;

  localparam int unsigned DmiAddrW = 7;
  localparam int unsigned DataW    = 32;

  localparam logic [DmiAddrW-1:0] SBCS       = 7'h38;
  localparam logic [DmiAddrW-1:0] SBAddress0 = 7'h39;
  localparam logic [DmiAddrW-1:0] SBData0    = 7'h3C;

  localparam logic [2:0] SbVersion     = 3'd1;
  localparam logic [6:0] SbASize       = 7'd32;
  localparam logic [2:0] SbAccessReset = 3'd2;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [2:0] sbversion;
    logic [5:0] zero0;
    logic       sbbusyerror;
    logic       sbbusy;
    logic       sbreadonaddr;
    logic [2:0] sbaccess;
    logic       sbautoincrement;
    logic       sbreadondata;
    logic [2:0] sberror;
    logic [6:0] sbasize;
    logic       sbaccess128;
    logic       sbaccess64;
    logic       sbaccess32;
    logic       sbaccess16;
    logic       sbaccess8;
  } sbcs_t;

endpackage

// File: rtl/dm_sba_regs.sv
// DMI-facing SBA registers (sbcs, sbaddress0, sbdata0) with bus-access triggers.
// Optional macro DM_SBA_AUTOINCR_EN enables sbcs.sbautoincrement and address reload.
module dm_sba_regs
  import dm::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                dmactive_i,
  input  logic                dmi_req_valid_i,
  output logic                dmi_req_ready_o,
  input  logic [DmiAddrW-1:0] dmi_req_addr_i,
  input  logic [1:0]          dmi_req_op_i,
  input  logic [DataW-1:0]    dmi_req_data_i,
  output logic                dmi_resp_valid_o,
  input  logic                dmi_resp_ready_i,
  output logic [DataW-1:0]    dmi_resp_data_o,
  output logic [DataW-1:0]    sbaddress_o,
  output logic                sbaddress_write_valid_o,
  output logic                sbreadonaddr_o,
  output logic                sbautoincrement_o,
  output logic [2:0]          sbaccess_o,
  output logic                sbreadondata_o,
  output logic [DataW-1:0]    sbdata_o,
  output logic                sbdata_read_valid_o,
  output logic                sbdata_write_valid_o,
  input  logic [DataW-1:0]    sbaddress_i,
  input  logic [DataW-1:0]    sbdata_i,
  input  logic                sbdata_valid_i,
  input  logic                sbbusy_i,
  input  logic                sberror_valid_i,
  input  logic [2:0]          sberror_i
);

`ifdef DM_SBA_AUTOINCR_EN
  localparam bit AutoIncrEn = 1'b1;
`else
  localparam bit AutoIncrEn = 1'b0;
`endif

  typedef enum logic {Idle, Resp} dmi_state_e;

  dmi_state_e       state_q;
  logic             req_ready_q, resp_valid_q;
  logic [DataW-1:0] resp_data_q;

  logic             sbbusyerror_q, sbreadonaddr_q, sbautoinc_q, sbreadondata_q;
  logic [2:0]       sbaccess_q, sberror_q;
  logic [DataW-1:0] sbaddress_q, sbdata_q;
  logic             addr_wr_q, rd_trig_q, wr_trig_q, trig_last_q, pend_rd_q;

  logic             accept, is_rd, is_wr, busy, err_blk;
  logic [DataW-1:0] rdata;
  logic             set_busyerr, sbcs_wr, addr_load, data_load;
  logic             addr_pulse, rd_pulse, wr_pulse;
  sbcs_t            sbcs_rd, sbcs_wdata;

  assign accept     = dmi_req_valid_i && req_ready_q;
  assign is_rd      = accept && (dmi_req_op_i == DTM_READ);
  assign is_wr      = accept && (dmi_req_op_i == DTM_WRITE);
  // A trigger issued last cycle counts as busy until the SBA control raises sbbusy_i.
  assign busy       = sbbusy_i || trig_last_q;
  assign err_blk    = sbbusyerror_q || (sberror_q != 3'd0);
  assign sbcs_wdata = sbcs_t'(dmi_req_data_i);

  always_comb begin : sbcs_readback
    sbcs_rd                 = '0;
    sbcs_rd.sbversion       = SbVersion;
    sbcs_rd.sbbusyerror     = sbbusyerror_q;
    sbcs_rd.sbbusy          = busy;
    sbcs_rd.sbreadonaddr    = sbreadonaddr_q;
    sbcs_rd.sbaccess        = sbaccess_q;
    sbcs_rd.sbautoincrement = sbautoinc_q;
    sbcs_rd.sbreadondata    = sbreadondata_q;
    sbcs_rd.sberror         = sberror_q;
    sbcs_rd.sbasize         = SbASize;
    sbcs_rd.sbaccess32      = 1'b1;
    sbcs_rd.sbaccess16      = 1'b1;
    sbcs_rd.sbaccess8       = 1'b1;
  end

  // Decode of the accepted DMI request into read data, register updates and triggers.
  always_comb begin : req_decode
    rdata       = '0;
    set_busyerr = 1'b0;
    sbcs_wr     = 1'b0;
    addr_load   = 1'b0;
    data_load   = 1'b0;
    addr_pulse  = 1'b0;
    rd_pulse    = 1'b0;
    wr_pulse    = 1'b0;
    if (is_rd) begin
      unique case (dmi_req_addr_i)
        SBCS:       rdata = sbcs_rd;
        SBAddress0: rdata = sbaddress_q;
        SBData0: begin
          rdata = sbdata_q;
          if (busy)                             set_busyerr = 1'b1;
          else if (sbreadondata_q && !err_blk)  rd_pulse    = 1'b1;
        end
        default:    rdata = '0;
      endcase
    end else if (is_wr) begin
      unique case (dmi_req_addr_i)
        SBCS:       sbcs_wr = 1'b1;
        SBAddress0: begin
          if (busy) begin
            set_busyerr = 1'b1;
          end else begin
            addr_load  = 1'b1;
            addr_pulse = 1'b1;
            rd_pulse   = sbreadonaddr_q && !err_blk;
          end
        end
        SBData0: begin
          if (busy) begin
            set_busyerr = 1'b1;
          end else if (!err_blk) begin
            data_load = 1'b1;
            wr_pulse  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // DMI handshake: one outstanding request, response one cycle after accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin : dmi_fsm
    if (!rst_ni) begin
      state_q      <= Idle;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      unique case (state_q)
        Idle: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            state_q      <= Resp;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= rdata;
          end
        end
        Resp: begin
          if (dmi_resp_ready_i) begin
            state_q      <= Idle;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : sba_regs
    if (!rst_ni) begin
      sbbusyerror_q  <= 1'b0;
      sbreadonaddr_q <= 1'b0;
      sbautoinc_q    <= 1'b0;
      sbreadondata_q <= 1'b0;
      sbaccess_q     <= SbAccessReset;
      sberror_q      <= 3'd0;
      sbaddress_q    <= '0;
      sbdata_q       <= '0;
      addr_wr_q      <= 1'b0;
      rd_trig_q      <= 1'b0;
      wr_trig_q      <= 1'b0;
      trig_last_q    <= 1'b0;
      pend_rd_q      <= 1'b0;
    end else if (!dmactive_i) begin
      sbbusyerror_q  <= 1'b0;
      sbreadonaddr_q <= 1'b0;
      sbautoinc_q    <= 1'b0;
      sbreadondata_q <= 1'b0;
      sbaccess_q     <= SbAccessReset;
      sberror_q      <= 3'd0;
      sbaddress_q    <= '0;
      sbdata_q       <= '0;
      addr_wr_q      <= 1'b0;
      rd_trig_q      <= 1'b0;
      wr_trig_q      <= 1'b0;
      trig_last_q    <= 1'b0;
      pend_rd_q      <= 1'b0;
    end else begin
      addr_wr_q   <= addr_pulse;
      rd_trig_q   <= rd_pulse;
      wr_trig_q   <= wr_pulse;
      trig_last_q <= rd_trig_q || wr_trig_q;

      sbbusyerror_q <= (sbbusyerror_q && !(sbcs_wr && sbcs_wdata.sbbusyerror)) || set_busyerr;
      if (sbcs_wr) begin
        sbreadonaddr_q <= sbcs_wdata.sbreadonaddr;
        sbautoinc_q    <= AutoIncrEn && sbcs_wdata.sbautoincrement;
        sbreadondata_q <= sbcs_wdata.sbreadondata;
        sbaccess_q     <= sbcs_wdata.sbaccess;
      end

      // A newly reported error overrides a same-cycle write-1-to-clear.
      if (sberror_valid_i) begin
        if (sberror_q == 3'd0) sberror_q <= sberror_i;
      end else if (sbcs_wr) begin
        sberror_q <= sberror_q & ~sbcs_wdata.sberror;
      end

      if (sbdata_valid_i && AutoIncrEn) sbaddress_q <= sbaddress_i;
      if (addr_load)                    sbaddress_q <= dmi_req_data_i;

      if (sbdata_valid_i && pend_rd_q) sbdata_q <= sbdata_i;
      if (data_load)                   sbdata_q <= dmi_req_data_i;

      if (rd_pulse)            pend_rd_q <= 1'b1;
      else if (sbdata_valid_i) pend_rd_q <= 1'b0;
    end
  end

  assign dmi_req_ready_o         = req_ready_q;
  assign dmi_resp_valid_o        = resp_valid_q;
  assign dmi_resp_data_o         = resp_data_q;
  assign sbaddress_o             = sbaddress_q;
  assign sbaddress_write_valid_o = addr_wr_q;
  assign sbreadonaddr_o          = sbreadonaddr_q;
  assign sbautoincrement_o       = sbautoinc_q;
  assign sbaccess_o              = sbaccess_q;
  assign sbreadondata_o          = sbreadondata_q;
  assign sbdata_o                = sbdata_q;
  assign sbdata_read_valid_o     = rd_trig_q;
  assign sbdata_write_valid_o    = wr_trig_q;

endmodule

// File: tb/tb_dm_sba_regs.sv
// Directed, table-driven bench for dm_sba_regs (honours DM_SBA_AUTOINCR_EN).
module tb_dm_sba_regs;
  import dm::*;

`ifdef DM_SBA_AUTOINCR_EN
  localparam logic [31:0] AI    = 32'h0001_0000;
  localparam logic [31:0] ADDR1 = 32'h0000_1004;
  localparam logic [31:0] ADDR2 = 32'h0000_1008;
`else
  localparam logic [31:0] AI    = 32'h0000_0000;
  localparam logic [31:0] ADDR1 = 32'h0000_1000;
  localparam logic [31:0] ADDR2 = 32'h0000_1000;
`endif
  localparam logic [31:0] SBCS_RST = 32'h2004_0407;
  localparam logic [31:0] SBCS_ROA = 32'h2014_0407;

  logic        clk_i = 1'b0, rst_ni = 1'b0, dmactive_i = 1'b1;
  logic        dmi_req_valid_i = 1'b0, dmi_req_ready_o;
  logic [6:0]  dmi_req_addr_i = '0;
  logic [1:0]  dmi_req_op_i = '0;
  logic [31:0] dmi_req_data_i = '0;
  logic        dmi_resp_valid_o, dmi_resp_ready_i = 1'b1;
  logic [31:0] dmi_resp_data_o, sbaddress_o, sbdata_o;
  logic        sbaddress_write_valid_o, sbreadonaddr_o, sbautoincrement_o, sbreadondata_o;
  logic [2:0]  sbaccess_o;
  logic        sbdata_read_valid_o, sbdata_write_valid_o;
  logic [31:0] sbaddress_i = '0, sbdata_i = '0;
  logic        sbdata_valid_i = 1'b0, sbbusy_i = 1'b0, sberror_valid_i = 1'b0;
  logic [2:0]  sberror_i = '0;

  int checks = 0, failures = 0;

  always #5 clk_i = ~clk_i;

  dm_sba_regs dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
    .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_req_addr_i(dmi_req_addr_i), .dmi_req_op_i(dmi_req_op_i),
    .dmi_req_data_i(dmi_req_data_i), .dmi_resp_valid_o(dmi_resp_valid_o),
    .dmi_resp_ready_i(dmi_resp_ready_i), .dmi_resp_data_o(dmi_resp_data_o),
    .sbaddress_o(sbaddress_o), .sbaddress_write_valid_o(sbaddress_write_valid_o),
    .sbreadonaddr_o(sbreadonaddr_o), .sbautoincrement_o(sbautoincrement_o),
    .sbaccess_o(sbaccess_o), .sbreadondata_o(sbreadondata_o), .sbdata_o(sbdata_o),
    .sbdata_read_valid_o(sbdata_read_valid_o), .sbdata_write_valid_o(sbdata_write_valid_o),
    .sbaddress_i(sbaddress_i), .sbdata_i(sbdata_i), .sbdata_valid_i(sbdata_valid_i),
    .sbbusy_i(sbbusy_i), .sberror_valid_i(sberror_valid_i), .sberror_i(sberror_i)
  );

  // evt: 0 none, 1 bus completion (evt_a/evt_d), 2 error report (code in evt_d[2:0])
  typedef struct {
    logic [1:0]  evt;
    logic [31:0] evt_a;
    logic [31:0] evt_d;
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_pulse;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [1:0] evt, input logic [31:0] ea, input logic [31:0] ed,
                              input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                              input logic busy, input logic [31:0] er, input logic [2:0] ep);
    vec_t v;
    v.evt = evt; v.evt_a = ea; v.evt_d = ed; v.op = op; v.addr = addr; v.wdata = wd;
    v.busy = busy; v.exp_rdata = er; v.exp_pulse = ep;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sideband(input logic [1:0] evt, input logic [31:0] ea, input logic [31:0] ed);
    if (evt == 2'd1) begin
      sbdata_valid_i = 1'b1; sbaddress_i = ea; sbdata_i = ed;
      @(negedge clk_i);
      sbdata_valid_i = 1'b0;
      @(negedge clk_i);
    end else if (evt == 2'd2) begin
      sberror_valid_i = 1'b1; sberror_i = ed[2:0];
      @(negedge clk_i);
      sberror_valid_i = 1'b0;
      @(negedge clk_i);
    end
  endtask

  // One DMI transaction with immediate response consumption; captures data and trigger pulses.
  task automatic xact(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [2:0] pl);
    int n = 0;
    while (!dmi_req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    dmi_resp_ready_i = 1'b1;
    dmi_req_valid_i  = 1'b1; dmi_req_op_i = op; dmi_req_addr_i = addr; dmi_req_data_i = wd;
    @(negedge clk_i);
    dmi_req_valid_i = 1'b0; dmi_req_op_i = 2'd0;
    rd = dmi_resp_data_o;
    pl = {sbaddress_write_valid_o, sbdata_read_valid_o, sbdata_write_valid_o};
    check("resp_latency", {31'd0, dmi_resp_valid_o && (n < 20)}, 32'd1);
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] rd, held;
    logic [2:0]  pl;

    add(0,0,0, 1, SBCS,       0,            0, SBCS_RST,               3'b000); // 0 reset readback
    add(0,0,0, 1, SBAddress0, 0,            0, 32'h0,                  3'b000);
    add(0,0,0, 2, SBCS,       32'h0014_0000,0, 32'h0,                  3'b000);
    add(0,0,0, 1, SBCS,       0,            0, SBCS_ROA,               3'b000);
    add(0,0,0, 2, SBAddress0, 32'h1000,     0, 32'h0,                  3'b110); // readonaddr
    add(1,32'h1000,32'hDEAD_BEEF, 1, SBData0, 0, 0, 32'hDEAD_BEEF,     3'b000); // 5
    add(0,0,0, 1, SBAddress0, 0,            0, 32'h1000,               3'b000);
    add(0,0,0, 2, SBCS,       32'h0015_0000,0, 32'h0,                  3'b000);
    add(0,0,0, 1, SBCS,       0,            0, SBCS_ROA | AI,          3'b000);
    add(0,0,0, 2, SBData0,    32'h55,       0, 32'h0,                  3'b001);
    add(1,32'h1004,32'hAAAA_AAAA, 1, SBAddress0, 0, 0, ADDR1,          3'b000); // 10
    add(0,0,0, 1, SBData0,    0,            0, 32'h55,                 3'b000);
    add(0,0,0, 2, SBData0,    32'h77,       1, 32'h0,                  3'b000); // busy
    add(0,0,0, 1, SBCS,       0,            0, SBCS_ROA | AI | 32'h0040_0000, 3'b000);
    add(0,0,0, 2, SBCS,       32'h0055_0000,0, 32'h0,                  3'b000);
    add(0,0,0, 1, SBCS,       0,            0, SBCS_ROA | AI,          3'b000); // 15
    add(2,0,32'd3, 1, SBCS,   0,            0, SBCS_ROA | AI | 32'h3000, 3'b000);
    add(2,0,32'd2, 1, SBCS,   0,            0, SBCS_ROA | AI | 32'h3000, 3'b000);
    add(0,0,0, 2, SBData0,    32'h99,       0, 32'h0,                  3'b000); // err_blk
    add(0,0,0, 1, SBData0,    0,            0, 32'h55,                 3'b000);
    add(0,0,0, 1, SBCS,       0,            0, SBCS_ROA | AI | 32'h3000, 3'b000); // 20
    add(0,0,0, 2, SBCS,       32'h0015_7000,0, 32'h0,                  3'b000);
    add(0,0,0, 1, SBCS,       0,            0, SBCS_ROA | AI,          3'b000);
    add(0,0,0, 1, 7'h10,      0,            0, 32'h0,                  3'b000); // unmapped
    add(0,0,0, 2, SBCS,       32'h0015_8000,0, 32'h0,                  3'b000);
    add(0,0,0, 1, SBData0,    0,            0, 32'h55,                 3'b010); // 25 readondata
    add(1,32'h1008,32'h1234_5678, 2, SBCS, 32'h0014_0000, 0, 32'h0,    3'b000);
    add(0,0,0, 1, SBData0,    0,            0, 32'h1234_5678,          3'b000);
    add(0,0,0, 1, SBAddress0, 0,            0, ADDR2,                  3'b000);

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_req_ready", {31'd0, dmi_req_ready_o}, 32'd0);
    check("rst_resp_valid", {31'd0, dmi_resp_valid_o}, 32'd0);
    check("rst_sbaccess", {29'd0, sbaccess_o}, 32'd2);
    check("rst_sbaddress", sbaddress_o, 32'd0);
    check("rst_pulses", {29'd0, sbaddress_write_valid_o, sbdata_read_valid_o, sbdata_write_valid_o}, 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_req_ready", {31'd0, dmi_req_ready_o}, 32'd1);

    foreach (vq[i]) begin
      sideband(vq[i].evt, vq[i].evt_a, vq[i].evt_d);
      sbbusy_i = vq[i].busy;
      xact(vq[i].op, vq[i].addr, vq[i].wdata, rd, pl);
      sbbusy_i = 1'b0;
      check($sformatf("vec%0d_rdata", i), rd, vq[i].exp_rdata);
      check($sformatf("vec%0d_pulses", i), {29'd0, pl}, {29'd0, vq[i].exp_pulse});
    end
    check("sbaddress_o", sbaddress_o, ADDR2);
    check("sbreadonaddr_o", {31'd0, sbreadonaddr_o}, 32'd1);
    check("sbautoincrement_o", {31'd0, sbautoincrement_o}, 32'd0);

    // Response held off for three cycles
    dmi_resp_ready_i = 1'b0;
    dmi_req_valid_i = 1'b1; dmi_req_op_i = 2'd1; dmi_req_addr_i = SBCS;
    @(negedge clk_i);
    dmi_req_valid_i = 1'b0; dmi_req_op_i = 2'd0;
    held = dmi_resp_data_o;
    check("stall_data0", held, SBCS_ROA);
    for (int c = 0; c < 3; c++) begin
      check("stall_resp_valid", {31'd0, dmi_resp_valid_o}, 32'd1);
      check("stall_req_ready", {31'd0, dmi_req_ready_o}, 32'd0);
      check("stall_data", dmi_resp_data_o, SBCS_ROA);
      @(negedge clk_i);
    end
    dmi_resp_ready_i = 1'b1;
    @(negedge clk_i);
    check("release_resp_valid", {31'd0, dmi_resp_valid_o}, 32'd0);
    check("release_req_ready", {31'd0, dmi_req_ready_o}, 32'd1);

    // dmactive low clears registers but DMI still answers
    dmactive_i = 1'b0;
    repeat (2) @(negedge clk_i);
    xact(2'd1, SBAddress0, 32'h0, rd, pl);
    check("inactive_sbaddress0", rd, 32'h0);
    xact(2'd1, SBCS, 32'h0, rd, pl);
    check("inactive_sbcs", rd, SBCS_RST);
    check("inactive_sbaccess_o", {29'd0, sbaccess_o}, 32'd2);
    check("inactive_sbdata_o", sbdata_o, 32'd0);
    dmactive_i = 1'b1;
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
